sha256_round_controller: RTL and testbench
==========================================

# sha256_round_controller

Sequencing controller for the SHA-256 compression datapath. Accepts one 512-bit block as 16 handshaked 32-bit words, then steps the 64 compression rounds. It drives the 6-bit address of the round-constant (K) look-up table, the message-schedule controls, and the hash-register update strobes. It holds no hash data itself; the working registers, message schedule and K table are separate blocks driven from these outputs.

## Interface
- None. Round count (64) and words per block (16) are fixed by SHA-256 and are not parameterised.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin processing one block; sampled only in IDLE
- first_block  in  1  sampled with start; 1 = load the SHA-256 initial hash values before this block
- abort  in  1  cancel the block in progress; ignored in IDLE
- msg_valid  in  1  message word present on the external data bus
- msg_ready  out  1  controller accepting message words
- w_load  out  1  = msg_valid & msg_ready; schedule captures the word at index word_idx
- word_idx  out  4  index 0..15 of the word being loaded
- hash_init  out  1  1-cycle pulse; hash registers load the initial hash values
- work_load  out  1  1-cycle pulse; working registers a..h copy the hash registers
- k_addr  out  6  K look-up table address = current round number
- round_en  out  1  working registers perform one compression round this cycle
- w_expand  out  1  schedule supplies an expanded W (rounds 16..63) instead of a loaded word
- hash_update  out  1  1-cycle pulse; H[i] <= H[i] + working[i] (mod 2^32)
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse; block complete, hash registers valid

## Operation
- States: IDLE, INIT, LOAD, ROUND, FINAL, DONE.
- IDLE -> INIT when start=1. first_block is latched into fb_q in the same cycle. start while busy is ignored.
- INIT (1 cycle):
  - work_load=1.
  - hash_init=fb_q.
  - When both are high, the datapath forwards the initial values into a..h. The controller does not serialise them.
- INIT -> LOAD.
- LOAD:
  - msg_ready=1.
  - Each cycle with msg_valid=1 is a transfer (w_load=1). word_idx increments after each transfer and starts at 0.
  - msg_valid=0 stalls. word_idx holds and no other output changes.
  - The transfer at word_idx=15 moves the FSM to ROUND.
- ROUND:
  - round_en=1 every cycle.
  - A 6-bit round counter starts at 0 and increments each cycle.
  - k_addr = the round counter.
  - w_expand=1 when counter >= 16.
  - The cycle with counter=63 moves the FSM to FINAL. The counter wraps to 0.
- FINAL (1 cycle): hash_update=1, then -> DONE.
- DONE (1 cycle): done=1, then -> IDLE. start is not accepted in DONE.
- abort in any non-IDLE state:
  - Next state is IDLE; fb_q clears.
  - hash_update and done are not asserted for that block.
  - Outputs that would have asserted in the abort cycle are suppressed. abort is decoded combinationally into the strobes (w_load, round_en, hash_update, done). msg_ready is forced 0.
  - Hash registers keep their previous values.
- Priority: rst > abort > normal transitions.
- Output defaults outside their state: word_idx=0 outside LOAD; k_addr=0 outside ROUND.

## Timing
- Reset values:
  - State IDLE; fb_q=0; word counter and round counter = 0.
  - All 1-bit outputs = 0.
  - word_idx=0, k_addr=0.
- All state-derived outputs are registered-state decodes, with no combinational path from start. w_load depends combinationally on msg_valid.
- K table is combinational: the K value for round r is valid in the same cycle as k_addr=r.
- Minimum latency (start sampled in cycle 0, msg_valid held high):
  - INIT: cycle 1.
  - LOAD: cycles 2..17.
  - ROUND: cycles 18..81.
  - FINAL: cycle 82.
  - DONE: cycle 83.
  - busy: high cycles 1..83.
- Each LOAD stall cycle adds one cycle to the total latency.
- Back-to-back blocks: the next start is accepted in cycle 84 (IDLE). Use first_block=0 to chain hash state.
- rst asserted mid-operation: next cycle all reset values. This is the same as abort, and additionally clears the counters.

## Test plan
- Reset: rst high 2 cycles mid-ROUND (k_addr=30) -> next cycle state IDLE, k_addr=0, busy=0, round_en=0, done=0.
- Nominal block: start=1 with first_block=1, msg_valid constant 1 -> required response:
  - hash_init=1 and work_load=1 in cycle 1.
  - w_load in cycles 2..17 with word_idx 0..15.
  - k_addr 0..63 in cycles 18..81; w_expand=1 exactly in cycles 34..81.
  - hash_update in cycle 82; done in cycle 83.
- Stall: msg_valid low for 5 cycles while word_idx=7 -> word_idx stays 7, no w_load, done delayed to cycle 88.
- Abort: abort=1 at k_addr=40 -> next cycle IDLE, no hash_update and no done ever for that block; a following start with first_block=0 gives hash_init=0 in INIT.
- Chaining and start-ignore: start pulsed every cycle continuously -> required response:
  - Only the IDLE-cycle starts are taken, and the first block's done is in cycle 83.
  - The second block enters INIT at cycle 85, with hash_init equal to the first_block value sampled in cycle 84.
- End-of-round boundary: check the k_addr 63 -> FINAL transition, and that the round counter is 0 at the next block's first ROUND cycle.

Source files
------------

// File: rtl/sha256_round_controller.sv
// sha256_round_controller
//
// Sequencing controller for the SHA-256 compression datapath. It takes one
// 512-bit block as 16 handshaked 32-bit words and then steps the 64 compression
// rounds. It holds no hash data. The working registers, the message schedule and
// the K table are separate blocks, and they are driven from the outputs below.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        begin one block (sampled only in IDLE)
//   first_block  sampled with start; 1 = load the initial hash values first
//   abort        cancel the block in progress (ignored in IDLE)
//   msg_valid    message word present on the external bus
//   msg_ready    controller accepting message words
//   w_load       schedule captures the word at word_idx
//   word_idx     index 0..15 of the word being loaded
//   hash_init    hash registers load the initial hash values
//   work_load    working registers a..h copy the hash registers
//   k_addr       K table address = current round
//   round_en     working registers perform one round
//   w_expand     schedule supplies an expanded W (rounds 16..63)
//   hash_update  H[i] <= H[i] + working[i]
//   busy         high in every state except IDLE
//   done         block complete, hash registers valid

module sha256_round_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       first_block,
    input  logic       abort,
    input  logic       msg_valid,
    output logic       msg_ready,
    output logic       w_load,
    output logic [3:0] word_idx,
    output logic       hash_init,
    output logic       work_load,
    output logic [5:0] k_addr,
    output logic       round_en,
    output logic       w_expand,
    output logic       hash_update,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StLoad,
        StRound,
        StFinal,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic       fb_q, fb_d;
    logic [3:0] word_cnt_q, word_cnt_d;
    logic [5:0] round_cnt_q, round_cnt_d;

    // abort is only meaningful once a block is in flight
    logic abort_act;
    assign abort_act = abort & (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            fb_q        <= 1'b0;
            word_cnt_q  <= 4'd0;
            round_cnt_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            fb_q        <= fb_d;
            word_cnt_q  <= word_cnt_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fb_d        = fb_q;
        word_cnt_d  = word_cnt_q;
        round_cnt_d = round_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StInit;
                    fb_d        = first_block;
                    // An aborted block may leave the counters mid-count.
                    // Every new block therefore starts them from zero.
                    word_cnt_d  = 4'd0;
                    round_cnt_d = 6'd0;
                end
            end
            StInit: begin
                state_d = StLoad;
            end
            StLoad: begin
                if (msg_valid) begin
                    word_cnt_d = word_cnt_q + 4'd1;
                    if (word_cnt_q == 4'd15) begin
                        state_d = StRound;
                    end
                end
            end
            StRound: begin
                round_cnt_d = round_cnt_q + 6'd1;
                if (round_cnt_q == 6'd63) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The strobes are suppressed in the abort cycle, so the counters
        // must not advance in that cycle either.
        if (abort_act) begin
            state_d     = StIdle;
            fb_d        = 1'b0;
            word_cnt_d  = word_cnt_q;
            round_cnt_d = round_cnt_q;
        end
    end

    always_comb begin
        msg_ready   = 1'b0;
        w_load      = 1'b0;
        word_idx    = 4'd0;
        hash_init   = 1'b0;
        work_load   = 1'b0;
        k_addr      = 6'd0;
        round_en    = 1'b0;
        w_expand    = 1'b0;
        hash_update = 1'b0;
        done        = 1'b0;
        busy        = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
            end
            StInit: begin
                work_load = ~abort_act;
                hash_init = fb_q & ~abort_act;
            end
            StLoad: begin
                msg_ready = ~abort_act;
                w_load    = msg_valid & ~abort_act;
                word_idx  = word_cnt_q;
            end
            StRound: begin
                k_addr   = round_cnt_q;
                round_en = ~abort_act;
                w_expand = (round_cnt_q >= 6'd16) & ~abort_act;
            end
            StFinal: begin
                hash_update = ~abort_act;
            end
            StDone: begin
                done = ~abort_act;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_round_controller.sv
module tb_sha256_round_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       first_block;
    logic       abort;
    logic       msg_valid;
    logic       msg_ready;
    logic       w_load;
    logic [3:0] word_idx;
    logic       hash_init;
    logic       work_load;
    logic [5:0] k_addr;
    logic       round_en;
    logic       w_expand;
    logic       hash_update;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    sha256_round_controller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_block(first_block),
        .abort      (abort),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .w_load     (w_load),
        .word_idx   (word_idx),
        .hash_init  (hash_init),
        .work_load  (work_load),
        .k_addr     (k_addr),
        .round_en   (round_en),
        .w_expand   (w_expand),
        .hash_update(hash_update),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {busy, work_load, hash_init, msg_ready, w_load, word_idx, round_en, k_addr,
    //  w_expand, hash_update, done}
    logic [18:0] obs;
    assign obs = {busy, work_load, hash_init, msg_ready, w_load, word_idx, round_en,
                  k_addr, w_expand, hash_update, done};

    // Expected output vector in cycle c after start was sampled in cycle 0.
    // msg_valid is low for sl cycles, beginning when word_idx = sw.
    function automatic logic [18:0] exp_vec(int c, int sw, int sl, bit fb);
        int   cc;
        logic e_busy, e_wl, e_hi, e_rdy, e_ren, e_wexp, e_hu, e_done;
        logic [3:0] e_idx;
        logic [5:0] e_k;
        if (sl > 0 && c >= 2 + sw && c < 2 + sw + sl) begin
            return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'(sw), 1'b0, 6'd0, 3'b000};
        end
        cc     = (c >= 2 + sw + sl) ? c - sl : c;
        e_busy = (cc >= 1 && cc <= 83);
        e_wl   = (cc == 1);
        e_hi   = (cc == 1) && fb;
        e_rdy  = (cc >= 2 && cc <= 17);
        e_idx  = e_rdy ? 4'(cc - 2) : 4'd0;
        e_ren  = (cc >= 18 && cc <= 81);
        e_k    = e_ren ? 6'(cc - 18) : 6'd0;
        e_wexp = (cc >= 34 && cc <= 81);
        e_hu   = (cc == 82);
        e_done = (cc == 83);
        return {e_busy, e_wl, e_hi, e_rdy, e_rdy, e_idx, e_ren, e_k, e_wexp, e_hu, e_done};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled at +3.
    task automatic cyc_begin();
        @(posedge clk);
        #1;
    endtask

    // The cycle in which start is sampled is cycle 0.
    task automatic start_block(input bit fb);
        cyc_begin();
        start       = 1'b1;
        first_block = fb;
        msg_valid   = 1'b1;
        abort       = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || msg_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_idle busy=%b msg_ready=%b required 0 0", busy, msg_ready);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        first_block = 1'b0;
        abort       = 1'b0;
        msg_valid   = 1'b0;
        cyc_begin();
        cyc_begin();
        rst = 1'b0;
        #2;
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL reset_values got %h required %h", obs, 19'd0);
        end
    endtask

    task automatic test_nominal();
        start_block(1'b1);
        for (int c = 1; c <= 84; c++) begin
            cyc_begin();
            start = 1'b0;
            #2;
            checks++;
            if (obs !== exp_vec(c, 0, 0, 1'b1)) begin
                errors++;
                $display("FAIL nominal cycle %0d got %h required %h", c, obs,
                         exp_vec(c, 0, 0, 1'b1));
            end
        end
    endtask

    task automatic test_stall();
        start_block(1'b1);
        for (int c = 1; c <= 89; c++) begin
            cyc_begin();
            start     = 1'b0;
            msg_valid = !(c >= 9 && c <= 13);
            #2;
            checks++;
            if (obs !== exp_vec(c, 7, 5, 1'b1)) begin
                errors++;
                $display("FAIL stall cycle %0d got %h required %h", c, obs,
                         exp_vec(c, 7, 5, 1'b1));
            end
        end
        msg_valid = 1'b1;
    endtask

    task automatic test_reset_mid_round();
        bit found;
        found = 1'b0;
        start_block(1'b1);
        for (int c = 1; c <= 200 && !found; c++) begin
            cyc_begin();
            start = 1'b0;
            #2;
            if (round_en === 1'b1 && k_addr === 6'd30) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_k30 timeout k_addr=%0d required 30", k_addr);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc_begin();
            if (i == 1) rst = 1'b0;
            #2;
            checks++;
            if (obs !== 19'd0) begin
                errors++;
                $display("FAIL reset_mid_round step %0d got %h required %h", i, obs, 19'd0);
            end
        end
    endtask

    task automatic test_abort();
        bit found;
        int bad;
        found = 1'b0;
        bad   = 0;
        start_block(1'b1);
        for (int c = 1; c <= 200 && !found; c++) begin
            cyc_begin();
            start = 1'b0;
            #2;
            if (round_en === 1'b1 && k_addr === 6'd40) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_k40 timeout k_addr=%0d required 40", k_addr);
        end
        abort = 1'b1;
        #1;
        checks++;
        if ({busy, round_en, w_expand, hash_update, done} !== 5'b10000) begin
            errors++;
            $display("FAIL abort_cycle got %b required %b",
                     {busy, round_en, w_expand, hash_update, done}, 5'b10000);
        end
        cyc_begin();
        abort = 1'b0;
        #2;
        checks++;
        if (obs !== 19'd0) begin
            errors++;
            $display("FAIL abort_idle got %h required %h", obs, 19'd0);
        end
        for (int i = 0; i < 60; i++) begin
            cyc_begin();
            #2;
            if (hash_update !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_completion bad_cycles=%0d required 0", bad);
        end
        // Following block without the initial values; round counter restarts at 0.
        start_block(1'b0);
        for (int c = 1; c <= 84; c++) begin
            cyc_begin();
            start = 1'b0;
            #2;
            checks++;
            if (obs !== exp_vec(c, 0, 0, 1'b0)) begin
                errors++;
                $display("FAIL after_abort cycle %0d got %h required %h", c, obs,
                         exp_vec(c, 0, 0, 1'b0));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] e;
        start_block(1'b1);
        for (int c = 1; c <= 170; c++) begin
            cyc_begin();
            start       = (c < 168);
            first_block = (c == 84) ? 1'b0 : 1'b1;
            #2;
            if (c <= 83) e = exp_vec(c, 0, 0, 1'b1);
            else if (c == 84) e = 19'd0;
            else e = exp_vec(c - 84, 0, 0, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back cycle %0d got %h required %h", c, obs, e);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_nominal();
        test_stall();
        test_reset_mid_round();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
